// File: rtl/wave_generator.sv
// wave_generator: multi-mode oscillator voice (triangle/saw/pulse) with a click-free gate/length drain.
// Optional macro WAVE_GEN_VOLUME_EN adds vol_in scaling behind one extra output pipeline stage.
module wave_generator #(
    parameter int PHASE_W = 32,
    parameter int AMP_W   = 8,
    parameter int LEN_W   = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    step_in,
    input  logic [PHASE_W-1:0]      phase_incr_in,
    input  logic [1:0]              mode_in,
    input  logic [7:0]              duty_in,
    input  logic                    gate_in,
    input  logic                    length_en_in,
    input  logic [LEN_W-1:0]        length_in,
`ifdef WAVE_GEN_VOLUME_EN
    input  logic [3:0]              vol_in,
`endif
    output logic                    active_out,
    output logic                    wrap_out,
    output logic signed [AMP_W-1:0] amp_out
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic signed [AMP_W-1:0] AMP_MAX = {1'b0, {(AMP_W-1){1'b1}}};
    localparam logic signed [AMP_W-1:0] AMP_MIN = {1'b1, {(AMP_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    gate_q, gate_d;
    logic                    wrap_q, wrap_d;
    logic                    active_q, active_d;
    logic signed [AMP_W-1:0] amp_q, amp_d;
    logic [PHASE_W:0]        sum;
    logic                    carry, rise, len_done;
    logic [1:0]              quad;
    logic [AMP_W-2:0]        frac;
    logic signed [AMP_W-1:0] tri_w, saw_w, pulse_w, shape, shape_gated;

    assign sum      = {1'b0, phase_q} + {1'b0, phase_incr_in};
    assign carry    = step_in & sum[PHASE_W];
    assign rise     = gate_in & ~gate_q;
    assign len_done = length_en_in & step_in & (len_q <= LEN_W'(1));

    // Quadrants 1 and 2 mirror the fraction; quadrants 2 and 3 take the negative half.
    assign quad    = phase_q[PHASE_W-1 -: 2];
    assign frac    = phase_q[PHASE_W-3 -: AMP_W-1];
    assign tri_w   = {quad[1], frac ^ {(AMP_W-1){quad[1] ^ quad[0]}}};
    assign saw_w   = {~phase_q[PHASE_W-1], phase_q[PHASE_W-2 -: AMP_W-1]};
    assign pulse_w = (phase_q[PHASE_W-1 -: 8] < duty_in) ? AMP_MAX : AMP_MIN;
    assign shape   = (mode_in == 2'd0) ? tri_w :
                     (mode_in == 2'd1) ? saw_w :
                     (mode_in == 2'd2) ? pulse_w : '0;
    assign shape_gated = (state_q == IDLE) ? '0 : shape;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        len_d    = len_q;
        gate_d   = gate_in;
        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                if (rise) begin
                    state_d = RUN;
                    len_d   = length_in;
                end
            end
            RUN: begin
                if (step_in) phase_d = sum[PHASE_W-1:0];
                if (length_en_in && step_in && len_q != '0) len_d = len_q - 1'b1;
                if (len_done || !gate_in) state_d = DRAIN;
            end
            DRAIN: begin
                if (phase_incr_in == '0 || carry) begin
                    phase_d = '0;
                    state_d = IDLE;
                end else if (step_in) begin
                    phase_d = sum[PHASE_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

`ifdef WAVE_GEN_VOLUME_EN
    logic signed [AMP_W-1:0] wave_q, wave_d;
    logic                    wrap1_q, wrap1_d;
    logic signed [AMP_W+4:0] prod;

    assign prod = (AMP_W+5)'(wave_q) * (AMP_W+5)'($signed({1'b0, vol_in}));

    always_comb begin
        wave_d  = shape_gated;
        wrap1_d = carry & (state_q != IDLE);
        amp_d   = prod[AMP_W+3:4];
        wrap_d  = wrap1_q;
    end
`else
    always_comb begin
        amp_d  = shape_gated;
        wrap_d = carry & (state_q != IDLE);
    end
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            len_q    <= '0;
            gate_q   <= 1'b0;
            amp_q    <= '0;
            wrap_q   <= 1'b0;
            active_q <= 1'b0;
`ifdef WAVE_GEN_VOLUME_EN
            wave_q   <= '0;
            wrap1_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            len_q    <= len_d;
            gate_q   <= gate_d;
            amp_q    <= amp_d;
            wrap_q   <= wrap_d;
            active_q <= active_d;
`ifdef WAVE_GEN_VOLUME_EN
            wave_q   <= wave_d;
            wrap1_q  <= wrap1_d;
`endif
        end
    end

    assign amp_out    = amp_q;
    assign wrap_out   = wrap_q;
    assign active_out = active_q;
endmodule

// File: tb/tb_wave_generator.sv
// tb_wave_generator: directed + randomized checks of wave_generator against an arithmetic reference model.
module tb_wave_generator;
    localparam int PW = 32;
    localparam int AW = 8;
    localparam int LW = 16;
    localparam longint TWO32 = 64'h1_0000_0000;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 step_in = 1'b0;
    logic [PW-1:0]        phase_incr_in = '0;
    logic [1:0]           mode_in = '0;
    logic [7:0]           duty_in = '0;
    logic                 gate_in = 1'b0;
    logic                 length_en_in = 1'b0;
    logic [LW-1:0]        length_in = '0;
    logic [3:0]           vol_in = 4'd15;
    logic                 active_out, wrap_out;
    logic signed [AW-1:0] amp_out;

    int n_tests = 0;
    int n_fail  = 0;

    int     m_state, m_cnt, m_amp, m_amp1, m_wrap, m_wrap1, m_active;
    longint m_phase;
    bit     m_gprev;

    wave_generator #(.PHASE_W(PW), .AMP_W(AW), .LEN_W(LW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in), .phase_incr_in(phase_incr_in),
        .mode_in(mode_in), .duty_in(duty_in), .gate_in(gate_in), .length_en_in(length_en_in),
        .length_in(length_in),
`ifdef WAVE_GEN_VOLUME_EN
        .vol_in(vol_in),
`endif
        .active_out(active_out), .wrap_out(wrap_out), .amp_out(amp_out));

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Sample value from the top phase bits: t spans 4 quadrants of 128, b is the top byte.
    function automatic int wave(input longint ph, input int mode, input int duty);
        int t = int'(ph >> 23);
        int b = int'(ph >> 24);
        case (mode)
            0: return t < 128 ? t : (t < 384 ? 255 - t : t - 512);
            1: return b - 128;
            2: return b < duty ? 127 : -128;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_cnt = 0; m_gprev = 0;
        m_amp = 0; m_amp1 = 0; m_wrap = 0; m_wrap1 = 0; m_active = 0;
    endtask

    task automatic model_step();
        longint sum;
        bit carry, done;
        int nw, nwrap, ns;
        if (rst_in) begin
            model_reset();
            return;
        end
        sum   = m_phase + longint'(phase_incr_in);
        carry = step_in && (sum >= TWO32);
        nw    = (m_state == 0) ? 0 : wave(m_phase, int'(mode_in), int'(duty_in));
        nwrap = (m_state != 0 && carry) ? 1 : 0;
        ns    = m_state;
        if (m_state == 0) begin
            m_phase = 0;
            if (gate_in && !m_gprev) begin
                ns = 1;
                m_cnt = int'(length_in);
            end
        end else if (m_state == 1) begin
            done = 0;
            if (step_in) m_phase = sum % TWO32;
            if (length_en_in && step_in) begin
                done = (m_cnt <= 1);
                if (m_cnt > 0) m_cnt--;
            end
            if (done || !gate_in) ns = 2;
        end else begin
            if (phase_incr_in == 0 || carry) begin
                m_phase = 0;
                ns = 0;
            end else if (step_in) begin
                m_phase = sum % TWO32;
            end
        end
`ifdef WAVE_GEN_VOLUME_EN
        m_amp  = (m_amp1 * int'(vol_in)) >>> 4;
        m_amp1 = nw;
        m_wrap = m_wrap1;
        m_wrap1 = nwrap;
`else
        m_amp  = nw;
        m_wrap = nwrap;
`endif
        m_state  = ns;
        m_active = (ns != 0) ? 1 : 0;
        m_gprev  = gate_in;
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        check("amp", int'(amp_out), m_amp);
        check("wrap", int'(wrap_out), m_wrap);
        check("active", int'(active_out), m_active);
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        rst_in = 1'b0;
        repeat (2) tick();

        // Triangle, full periods then drain
        mode_in = 2'd0; phase_incr_in = 32'h0400_0000; step_in = 1'b1; gate_in = 1'b1;
        repeat (140) tick();
        gate_in = 1'b0;
        repeat (70) tick();

        // Length expiry with gate held high
        length_en_in = 1'b1; length_in = 16'd3; phase_incr_in = 32'h4000_0000; gate_in = 1'b1;
        repeat (12) tick();
        gate_in = 1'b0; length_en_in = 1'b0;
        repeat (3) tick();

        // Sawtooth gate release
        mode_in = 2'd1; phase_incr_in = 32'h1000_0000; gate_in = 1'b1;
        repeat (6) tick();
        gate_in = 1'b0;
        repeat (20) tick();

        // Pulse, duty 64
        mode_in = 2'd2; duty_in = 8'd64; phase_incr_in = 32'h0100_0000; gate_in = 1'b1;
        repeat (520) tick();
        gate_in = 1'b0;
        repeat (270) tick();

        // Async reset mid-note, between clock edges
        mode_in = 2'd0; phase_incr_in = 32'h0400_0000; gate_in = 1'b1;
        repeat (20) tick();
        #2 rst_in = 1'b1;
        #1;
        check("rst_amp", int'(amp_out), 0);
        check("rst_wrap", int'(wrap_out), 0);
        check("rst_active", int'(active_out), 0);
        model_reset();
        tick();
        rst_in = 1'b0;
        repeat (10) tick();
        gate_in = 1'b0;
        repeat (70) tick();

        // Silence mode while running
        mode_in = 2'd3; gate_in = 1'b1;
        repeat (5) tick();
        check("silence_amp", int'(amp_out), 0);
        check("silence_active", int'(active_out), 1);
        gate_in = 1'b0;
        repeat (70) tick();

        // Zero increment then release must not hang in DRAIN
        mode_in = 2'd0; gate_in = 1'b1;
        repeat (5) tick();
        phase_incr_in = '0;
        tick();
        gate_in = 1'b0;
        repeat (2) tick();
        check("zero_incr_idle", int'(active_out), 0);
        repeat (2) tick();

        // Randomized stimulus
        for (int i = 0; i < 4000; i++) begin
            step_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 30) == 0) mode_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0) duty_in = 8'($urandom());
            if ($urandom_range(0, 20) == 0)
                phase_incr_in = ($urandom_range(0, 15) == 0) ? '0 : $urandom() >> $urandom_range(0, 8);
            if ($urandom_range(0, 25) == 0) gate_in = ~gate_in;
            if ($urandom_range(0, 25) == 0) length_en_in = 1'($urandom());
            if ($urandom_range(0, 25) == 0) length_in = 16'($urandom_range(0, 8));
            if ($urandom_range(0, 25) == 0) vol_in = 4'($urandom());
            if ($urandom_range(0, 600) == 0) begin
                rst_in = 1'b1;
                tick();
                rst_in = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
